// File: rtl/cluster_ce_pkg.sv
// Shared constants and coordinate helpers for the kd-tree compare-exchange node.
package cluster_ce_pkg;
  localparam int unsigned dim         = 3;
  localparam int unsigned data_range  = 255;
  localparam int unsigned dim_size    = $clog2(data_range);
  localparam int unsigned center_size = dim * dim_size;
  localparam int unsigned axis_size   = $clog2(dim);

  typedef logic [center_size-1:0] center_t;
  typedef logic [dim_size-1:0]    coord_t;
  typedef logic [axis_size-1:0]   axis_t;

  // Loop-select keeps the slice in range even for an out-of-range k.
  function automatic coord_t get_coord(input center_t c, input axis_t k);
    coord_t r;
    r = '0;
    for (int unsigned i = 0; i < dim; i++) begin
      if (k == axis_size'(i)) r = c[i*dim_size +: dim_size];
    end
    return r;
  endfunction

  function automatic axis_t eff_axis(input axis_t a);
    return (a >= axis_size'(dim)) ? '0 : a;
  endfunction

  function automatic axis_t next_axis(input axis_t a);
    return (a == axis_size'(dim - 1)) ? '0 : a + axis_size'(1);
  endfunction
endpackage

// File: rtl/cluster_ce_if.sv
// Data/control bundle between the tree-level controller and one cluster_ce node.
interface cluster_ce_if;
  import cluster_ce_pkg::*;

  logic    en;
  logic    sorting;
  logic    left_en;
  logic    right_en;
  center_t left;
  center_t parent;
  center_t right;
  center_t point_in;
  axis_t   axis;

  logic    stable;
  logic    left_switch;
  logic    parent_switch;
  logic    right_switch;
  center_t new_left;
  center_t new_parent;
  center_t new_right;
  axis_t   child_axis;

  modport master (
    output en, sorting, left_en, right_en, left, parent, right, point_in, axis,
    input  stable, left_switch, parent_switch, right_switch,
           new_left, new_parent, new_right, child_axis
  );

  modport slave (
    input  en, sorting, left_en, right_en, left, parent, right, point_in, axis,
    output stable, left_switch, parent_switch, right_switch,
           new_left, new_parent, new_right, child_axis
  );
endinterface

// File: rtl/cluster_ce_swap.sv
// Two-input compare-exchange on one axis; swaps only when a's key is strictly greater.
module ce_swap2
  import cluster_ce_pkg::*;
(
  input  logic    en,
  input  axis_t   axis,
  input  center_t a,
  input  center_t b,
  output center_t lo,
  output center_t hi
);
  logic swap;

  always_comb begin
    swap = en & (get_coord(a, axis) > get_coord(b, axis));
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/cluster_ce.sv
// kd-tree compare-exchange node: sorts parent/children on the split axis or routes a query point.
module cluster_ce
  import cluster_ce_pkg::*;
(
  input logic         clk,
  input logic         rst,
  cluster_ce_if.slave bus
);
  axis_t   ax;
  center_t l1, p1, p2, r2, l3, p3;
  coord_t  point_key, parent_key;

  logic    nxt_stable, nxt_ls, nxt_ps, nxt_rs;
  center_t nxt_l, nxt_p, nxt_r;

  assign ax = eff_axis(bus.axis);

  // Stage enables collapse the 3-stage network to a single (child,parent) compare
  // when only one child is present.
  ce_swap2 u_stage1 (.en(bus.left_en), .axis(ax), .a(bus.left), .b(bus.parent), .lo(l1), .hi(p1));
  ce_swap2 u_stage2 (.en(bus.right_en), .axis(ax), .a(p1), .b(bus.right), .lo(p2), .hi(r2));
  ce_swap2 u_stage3 (.en(bus.left_en & bus.right_en), .axis(ax), .a(l1), .b(p2), .lo(l3), .hi(p3));

  always_comb begin
    nxt_l      = bus.left;
    nxt_p      = bus.parent;
    nxt_r      = bus.right;
    nxt_ls     = 1'b0;
    nxt_ps     = 1'b0;
    nxt_rs     = 1'b0;
    nxt_stable = 1'b1;
    point_key  = get_coord(bus.point_in, ax);
    parent_key = get_coord(bus.parent, ax);
    if (bus.sorting) begin
      nxt_l      = l3;
      nxt_p      = p3;
      nxt_r      = r2;
      nxt_ls     = (l3 != bus.left);
      nxt_ps     = (p3 != bus.parent);
      nxt_rs     = (r2 != bus.right);
      nxt_stable = ~(nxt_ls | nxt_ps | nxt_rs);
    end else begin
      nxt_ls = bus.left_en & (point_key < parent_key);
      nxt_rs = bus.right_en & (point_key >= parent_key);
      nxt_ps = ~(nxt_ls | nxt_rs);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.stable        <= 1'b0;
      bus.left_switch   <= 1'b0;
      bus.parent_switch <= 1'b0;
      bus.right_switch  <= 1'b0;
      bus.new_left      <= '0;
      bus.new_parent    <= '0;
      bus.new_right     <= '0;
      bus.child_axis    <= '0;
    end else if (bus.en) begin
      bus.stable        <= nxt_stable;
      bus.left_switch   <= nxt_ls;
      bus.parent_switch <= nxt_ps;
      bus.right_switch  <= nxt_rs;
      bus.new_left      <= nxt_l;
      bus.new_parent    <= nxt_p;
      bus.new_right     <= nxt_r;
      bus.child_axis    <= next_axis(ax);
    end
  end
endmodule

// File: tb/tb_cluster_ce.sv
// Directed self-checking bench for cluster_ce with hand-computed expectations.
module tb_cluster_ce;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cluster_ce_if bus ();

  cluster_ce u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sw is {left_switch, parent_switch, right_switch}
  task automatic expect_out(input string tag, input logic [23:0] l, input logic [23:0] p,
                            input logic [23:0] r, input logic [2:0] sw, input logic st,
                            input logic [1:0] ca);
    chk({tag, ".new_left"},   32'(bus.new_left),   32'(l));
    chk({tag, ".new_parent"}, 32'(bus.new_parent), 32'(p));
    chk({tag, ".new_right"},  32'(bus.new_right),  32'(r));
    chk({tag, ".switches"},
        32'({bus.left_switch, bus.parent_switch, bus.right_switch}), 32'(sw));
    chk({tag, ".stable"},     32'(bus.stable),     32'(st));
    chk({tag, ".child_axis"}, 32'(bus.child_axis), 32'(ca));
  endtask

  task automatic apply(input logic srt, input logic le, input logic re, input logic [1:0] ax,
                       input logic [23:0] l, input logic [23:0] p, input logic [23:0] r,
                       input logic [23:0] pt);
    bus.sorting  = srt;
    bus.left_en  = le;
    bus.right_en = re;
    bus.axis     = ax;
    bus.left     = l;
    bus.parent   = p;
    bus.right    = r;
    bus.point_in = pt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.sorting = 1'b1; bus.left_en = 1'b1; bus.right_en = 1'b1; bus.axis = 2'd0;
    bus.left = 24'd0; bus.parent = 24'd0; bus.right = 24'd0; bus.point_in = 24'd0;
    #3 rst = 1'b0;
    #4;
    expect_out("reset", 24'd0, 24'd0, 24'd0, 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;

    apply(1, 1, 1, 2'd0, 24'd101, 24'd102, 24'd103, 24'd0);
    expect_out("sorted", 24'd101, 24'd102, 24'd103, 3'b000, 1'b1, 2'd1);
    apply(1, 1, 1, 2'd0, 24'd150, 24'd99, 24'd233, 24'd0);
    expect_out("lp_swap", 24'd99, 24'd150, 24'd233, 3'b110, 1'b0, 2'd1);
    apply(1, 1, 1, 2'd0, 24'd5, 24'd1, 24'd3, 24'd0);
    expect_out("rot_a", 24'd1, 24'd3, 24'd5, 3'b111, 1'b0, 2'd1);
    apply(1, 1, 1, 2'd0, 24'd32, 24'd167, 24'd17, 24'd0);
    expect_out("rot_b", 24'd17, 24'd32, 24'd167, 3'b111, 1'b0, 2'd1);
    apply(1, 1, 1, 2'd0, 24'd255, 24'd254, 24'd253, 24'd0);
    expect_out("reverse", 24'd253, 24'd254, 24'd255, 3'b101, 1'b0, 2'd1);
    apply(1, 1, 1, 2'd0, 24'd50, 24'd50, 24'd50, 24'd0);
    expect_out("ties", 24'd50, 24'd50, 24'd50, 3'b000, 1'b1, 2'd1);
    apply(1, 0, 1, 2'd0, 24'd9, 24'd5, 24'd3, 24'd0);
    expect_out("no_left", 24'd9, 24'd3, 24'd5, 3'b011, 1'b0, 2'd1);
    apply(1, 1, 0, 2'd0, 24'd9, 24'd5, 24'd3, 24'd0);
    expect_out("no_right", 24'd5, 24'd9, 24'd3, 3'b110, 1'b0, 2'd1);
    apply(1, 0, 0, 2'd0, 24'd9, 24'd5, 24'd3, 24'd0);
    expect_out("no_child", 24'd9, 24'd5, 24'd3, 3'b000, 1'b1, 2'd1);
    // byte-1 keys 5/1/3; byte-0 keys would order differently
    apply(1, 1, 1, 2'd1, 24'h000501, 24'h000109, 24'h000305, 24'd0);
    expect_out("axis1", 24'h000109, 24'h000305, 24'h000501, 3'b111, 1'b0, 2'd2);
    apply(1, 1, 1, 2'd2, 24'h000501, 24'h000109, 24'h000305, 24'd0);
    expect_out("axis2", 24'h000501, 24'h000109, 24'h000305, 3'b000, 1'b1, 2'd0);

    apply(0, 1, 1, 2'd0, 24'd7, 24'd100, 24'd200, 24'd100);
    expect_out("route_eq", 24'd7, 24'd100, 24'd200, 3'b001, 1'b1, 2'd1);
    apply(0, 1, 1, 2'd0, 24'd7, 24'd100, 24'd200, 24'd99);
    expect_out("route_lt", 24'd7, 24'd100, 24'd200, 3'b100, 1'b1, 2'd1);
    apply(0, 0, 0, 2'd0, 24'd7, 24'd100, 24'd200, 24'd99);
    expect_out("route_term", 24'd7, 24'd100, 24'd200, 3'b010, 1'b1, 2'd1);

    bus.en = 1'b0;
    apply(1, 1, 1, 2'd1, 24'd5, 24'd1, 24'd3, 24'd0);
    apply(1, 1, 1, 2'd2, 24'd150, 24'd99, 24'd233, 24'd0);
    expect_out("hold", 24'd7, 24'd100, 24'd200, 3'b010, 1'b1, 2'd1);

    bus.en = 1'b1;
    apply(1, 1, 1, 2'd0, 24'd5, 24'd1, 24'd3, 24'd0);
    expect_out("pre_rst", 24'd1, 24'd3, 24'd5, 3'b111, 1'b0, 2'd1);
    #2 rst = 1'b0;
    #1;
    expect_out("async_rst", 24'd0, 24'd0, 24'd0, 3'b000, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    expect_out("rst_over_en", 24'd0, 24'd0, 24'd0, 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    apply(1, 1, 1, 2'd0, 24'd150, 24'd99, 24'd233, 24'd0);
    expect_out("post_rst", 24'd99, 24'd150, 24'd233, 3'b110, 1'b0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cluster_ce.md
# cluster_ce

Compare-exchange node for the hardware kd-tree used by the k-means clustering engine. Each instance owns one tree level position and sees its parent center and up to two child centers. In sort mode it reorders the three centers along the node's split axis so that left ≤ parent ≤ right, and reports which positions changed. In route mode it reports which subtree a query point descends into.

## Interface
- dim, 3, number of coordinates per center
- data_range, 255, maximum coordinate value
- dim_size, $clog2(data_range) (= 8), bits per coordinate
- center_size, dim*dim_size (= 24), bits per packed center
- axis_size, $clog2(dim) (= 2), bits of axis index

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  capture enable; outputs update only when 1
- sorting  in  1  1 = sort mode, 0 = route mode
- left_en  in  1  left child present
- right_en  in  1  right child present
- left, parent, right  in  center_size each  current centers
- point_in  in  center_size  query point (route mode)
- axis  in  axis_size  split axis of this node
- stable  out  1  no exchange occurred
- left_switch, parent_switch, right_switch  out  1 each  position changed / route direction
- new_left, new_parent, new_right  out  center_size each  reordered centers
- child_axis  out  axis_size  split axis for the child level

## Operation
- Coordinate k occupies bits [k*dim_size+dim_size-1 : k*dim_size]; axis 0 is the LSB slice. Keys are unsigned.
- An axis value ≥ dim is treated as axis 0.
- child_axis = (axis+1) mod dim.
- Sort mode, both children enabled: three-stage compare-exchange on keys, swapping only on strict >. Stage 1 (L,P), stage 2 (P,R), stage 3 (L,P). Ties never swap.
- Sort mode, one child enabled: only parent and that child are compared. The left child swaps if left > parent. The right child swaps if parent > right. The absent child's output equals its input.
- Sort mode, no child enabled: passthrough.
- X_switch = 1 iff new_X ≠ X at the bit level. stable = ~(left_switch | parent_switch | right_switch).
- Route mode: new_* = inputs unchanged, and stable = 1.
  - left_switch = left_en & (point_in[axis] < parent[axis]).
  - right_switch = right_en & (point_in[axis] ≥ parent[axis]).
  - parent_switch = 1 when neither of the above is asserted, meaning the point terminates at this node.

## Timing
- All outputs are registered. Each is loaded on the rising clk edge when en = 1. Latency is 1 cycle from input to output.
- When en = 0, all outputs hold their values.
- Reset (rst = 0, asynchronous) drives all outputs to 0, including stable = 0. Reset takes priority over en at any time, including mid-sort. The first capture after reset release is normal.
- Inputs may change every cycle. There is no handshake and the node is fully pipelined at 1 result per cycle.
- Sorting a whole tree requires the parent controller to iterate levels until every node reports stable. That iteration is outside this block.

## Structure
- Shared package holds the dim, dim_size, center_size and axis_size constants. It also holds a center-slice function: get coordinate k of a center.
- One sub-module, ce_swap2: a 2-input compare-exchange on a selected axis with strict-> swap. It is instantiated 3× for the sort network. The route comparison reuses the same key extraction.

## Test plan
All sort scenarios below use axis=0, sorting=1, and left_en=right_en=1. Only the low byte of each center is non-zero.
- l=101, p=102, r=103 → outputs 101/102/103, all switches 0, stable=1.
- l=150, p=99, r=233 → 99/150/233, left_switch=1, parent_switch=1, right_switch=0, stable=0.
- l=5, p=1, r=3 → 1/3/5, all switches 1. Also l=32, p=167, r=17 → 17/32/167, all switches 1.
- l=255, p=254, r=253 → 253/254/255, left_switch=1, right_switch=1, parent_switch=0. Also l=50, p=50, r=50 → no swap, stable=1.
- Children and axis control:
  - left_en=0, l=9, p=5, r=3 → new_left=9, new_parent=3, new_right=5.
  - axis=1 with keys in byte 1 → sort follows byte 1.
  - child_axis sequence 0→1, 1→2, 2→0.
- Route mode with p=100, point=100 → right_switch=1. Point=99 → left_switch=1. Both children disabled → parent_switch=1.
- Control: en=0 holds outputs across changing inputs. Asserting rst mid-run zeroes all outputs immediately, without waiting for a clock edge.
